return_address_stack: RTL

- Circular hardware stack of return addresses for the fetch stage.
- On a call (jal/jalr), the PC+4 value produced by the PC adder is pushed.
- On a return (jr $ra), the top entry is presented as the predicted next PC and popped.
- Sits beside the PC register and PC-select mux. Consumes the PC+4 path in the opposite direction: it stores that value and hands it back later.

---
 rtl/return_address_stack_pkg.sv | 15 +
 rtl/return_address_stack.sv | 118 +++++++++++
 2 files changed

// File: rtl/return_address_stack_pkg.sv
// Shared constants for the fetch-stage return address stack.
package return_address_stack_pkg;

  // Default number of stack entries.
  localparam int RAS_DEPTH = 8;

  // Full byte-address width and the stored word-address width.
  localparam int RAS_ADDR_W = 32;
  localparam int RAS_WORD_W = 30;

  // Zero pad that re-aligns a stored word address to a byte address.
  localparam int                  RAS_PAD_W     = RAS_ADDR_W - RAS_WORD_W;
  localparam logic [RAS_PAD_W-1:0] RAS_ALIGN_PAD = '0;

endpackage : return_address_stack_pkg

// File: rtl/return_address_stack.sv
// Circular return address stack: call pushes PC+4, return pops the
// predicted target. When full, a push overwrites the oldest entry.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Push,
  input  logic [RAS_ADDR_W-1:0] PushAddr,
  input  logic                  Pop,
  input  logic                  Flush,
  output logic [RAS_ADDR_W-1:0] TopAddr,
  output logic                  TopValid,
  output logic [PTR_W:0]        Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int              CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [RAS_WORD_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic             empty;

  logic [RAS_WORD_W-1:0] push_word;
  logic                  unused_low_bits;

  assign push_word       = PushAddr[RAS_ADDR_W-1:RAS_PAD_W];
  assign unused_low_bits = ^PushAddr[RAS_PAD_W-1:0];

  assign top_idx = tos_q - PTR_W'(1);
  assign empty   = (count_q == '0);

  // Next-state decode: flush first, then the push/pop combination.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    tos_d       = tos_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = tos_q;

    if (Flush) begin
      tos_d   = '0;
      count_d = '0;
    end else if (Push && Pop && !empty) begin
      // Replace the top entry in place; depth is unchanged.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (Push) begin
      wr_en = 1'b1;
      tos_d = tos_q + PTR_W'(1);
      if (count_q == FULL) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (Pop) begin
      if (!empty) begin
        tos_d   = top_idx;
        count_d = count_q - CNT_W'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage write port; reset still blocks the write.
  always_ff @(posedge Clk) begin
    // NOTE: the array has no reset; Count alone decides which entries are meaningful.
    if (wr_en && !Reset) begin
      mem_q[wr_idx] <= push_word;
    end
  end

  // Combinational top-of-stack read from registered state.
  always_comb begin
    TopAddr = '0;
    if (!empty) begin
      TopAddr = {mem_q[top_idx], RAS_ALIGN_PAD};
    end
  end

  assign TopValid  = !empty;
  assign Count     = count_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

endmodule : return_address_stack
